// File: rtl/i2cslave_if.sv
// I2C bus pins seen by the target: sampled clock/data inputs and the
// open-drain data output (0 = pull low, 1 = release).
interface i2cslave_if;
  logic scli;
  logic sdai;
  logic sdao;

  modport master (output scli, output sdai, input sdao);
  modport slave  (input scli, input sdai, output sdao);
endinterface

// File: rtl/i2cslave.sv
// I2C target with a 7-bit address and a small byte register file that the
// bus and the arm processor share. A bus write sets the register pointer and
// then stores data bytes. A bus read returns bytes from the pointer onwards.
// The pointer auto-increments and wraps at NREGS. No clock stretching.
module i2cslave #(
  parameter logic [6:0]  SLAVEADDR = 7'h50,
  parameter int unsigned NREGS     = 16,
  parameter int unsigned FILTER    = 3,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  i2cslave_if.slave     bus,
  input  logic [AW-1:0] armaddr,
  input  logic          armwrite,
  input  logic [7:0]    armwdata,
  output logic [7:0]    armrdata,
  output logic          wrstrobe,
  output logic [AW-1:0] wraddr,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, AACK, PTR, PACK, WDATA, WACK, RDATA, RACK
  } state_t;

  state_t state, state_n;

  logic [1:0]        scl_sync, sda_sync;
  logic [FILTER-1:0] scl_hist, sda_hist;
  logic              scl_f, sda_f, scl_q, sda_q;
  logic              scl_rise, scl_fall, start, stop;

  logic [7:0]    regs [NREGS];
  logic [7:0]    shreg, shreg_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [AW-1:0] ptr, ptr_n;
  logic          sdo, sdo_n;
  logic          busy_n;
  logic          bus_we;

  // Two-flop synchronisers for the asynchronous bus pins; the idle bus is high.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scli};
      sda_sync <= {sda_sync[0], bus.sdai};
    end
  end

  // Glitch filter: the filtered level follows only after FILTER equal samples.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_hist <= (scl_hist << 1) | FILTER'(scl_sync[1]);
      sda_hist <= (sda_hist << 1) | FILTER'(sda_sync[1]);
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop     = scl_f & scl_q & ~sda_q & sda_f;

  // Protocol state and datapath registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      ptr      <= '0;
      sdo      <= 1'b1;
      busy     <= 1'b0;
      wrstrobe <= 1'b0;
      wraddr   <= '0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bitcnt   <= bitcnt_n;
      ptr      <= ptr_n;
      sdo      <= sdo_n;
      busy     <= busy_n;
      wrstrobe <= bus_we;
      if (bus_we) wraddr <= ptr;
    end
  end

  assign bus.sdao = sdo;

  // Next-state logic. START/STOP override bit handling in every state.
  // Each ACK slot is its own state so the byte states only count data bits.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    ptr_n    = ptr;
    sdo_n    = sdo;
    busy_n   = busy;
    bus_we   = 1'b0;
    if (start) begin
      state_n  = ADDR;
      bitcnt_n = '0;
      sdo_n    = 1'b1;
    end else if (stop) begin
      state_n = IDLE;
      sdo_n   = 1'b1;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shreg_n  = {shreg[6:0], sda_f};
            bitcnt_n = bitcnt + 4'd1;
          end else if (scl_fall && bitcnt == 4'd8) begin
            bitcnt_n = '0;
            if (shreg[7:1] == SLAVEADDR) begin
              sdo_n   = 1'b0;
              busy_n  = 1'b1;
              state_n = AACK;
            end else begin
              busy_n  = 1'b0;
              state_n = IDLE;
            end
          end
        end
        AACK: begin
          if (scl_fall) begin
            bitcnt_n = '0;
            if (!shreg[0]) begin
              sdo_n   = 1'b1;
              state_n = PTR;
            end else begin
              shreg_n = regs[ptr];
              sdo_n   = regs[ptr][7];
              state_n = RDATA;
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            shreg_n  = {shreg[6:0], sda_f};
            bitcnt_n = bitcnt + 4'd1;
          end else if (scl_fall && bitcnt == 4'd8) begin
            bitcnt_n = '0;
            ptr_n    = shreg[AW-1:0];
            sdo_n    = 1'b0;
            state_n  = PACK;
          end
        end
        PACK: begin
          if (scl_fall) begin
            sdo_n   = 1'b1;
            state_n = WDATA;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shreg_n  = {shreg[6:0], sda_f};
            bitcnt_n = bitcnt + 4'd1;
          end else if (scl_fall && bitcnt == 4'd8) begin
            bitcnt_n = '0;
            bus_we   = 1'b1;
            ptr_n    = ptr + 1'b1;
            sdo_n    = 1'b0;
            state_n  = WACK;
          end
        end
        WACK: begin
          if (scl_fall) begin
            sdo_n   = 1'b1;
            state_n = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bitcnt == 4'd7) begin
              bitcnt_n = '0;
              sdo_n    = 1'b1;
              state_n  = RACK;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sdo_n    = shreg[6];
              bitcnt_n = bitcnt + 4'd1;
            end
          end
        end
        RACK: begin
          // A falling edge here always follows an ACK: a NACK already left.
          if (scl_rise) begin
            if (!sda_f) begin
              ptr_n = ptr + 1'b1;
            end else begin
              busy_n  = 1'b0;
              sdo_n   = 1'b1;
              state_n = IDLE;
            end
          end else if (scl_fall) begin
            bitcnt_n = '0;
            shreg_n  = regs[ptr];
            sdo_n    = regs[ptr][7];
            state_n  = RDATA;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Register file: the arm write is issued last so it wins a same-cycle clash.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      armrdata <= '0;
    end else begin
      if (bus_we)   regs[ptr]     <= shreg;
      if (armwrite) regs[armaddr] <= armwdata;
      armrdata <= regs[armaddr];
    end
  end

endmodule
